// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// Purpose:
//   Multi-channel push-button conditioner. Each of the N_KEYS raw, asynchronous
//   key pins is synchronised, debounced with a stable-count filter, and turned
//   into a debounced level plus one-cycle press / release / long-press pulses.
//   The long-press pulse can optionally auto-repeat while the key stays held.
//
// Parameters:
//   N_KEYS          number of independent key channels
//   ACTIVE_LOW      1: pressed = pin low, 0: pressed = pin high
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level (>=1)
//   LONG_CYCLES     cycles after the press pulse until key_long (0 = disabled)
//   REPEAT_CYCLES   period of further key_long pulses while held (0 = single)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   key_in       raw key pins, asynchronous to clk
//   key_state    debounced level per channel, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
//   key_long     one-cycle pulse(s) while a key is held long enough
// -----------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int N_KEYS          = 3,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    // Pin level of a released key; also the polarity mask turning pins into
    // "1 = pressed" after synchronisation.
    localparam logic [N_KEYS-1:0] IDLE_VEC = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    // The hold counter has to reach the larger of the two hold intervals.
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);
    localparam int LL   = (LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0;
    localparam int RL   = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [HW-1:0] LLAST = HW'(LL);
    localparam logic [HW-1:0] RLAST = HW'(RL);
    localparam logic [HW-1:0] HSAT  = HW'(HMAX);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] raw;

    // Two-flop synchroniser; reset loads the idle pin level so that no press
    // is seen while the chain refills after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign raw = sync2 ^ IDLE_VEC;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic          state_q;
        logic          press_q;
        logic          release_q;
        logic [DW-1:0] dcnt;
        logic          accept;

        // A new level is taken only after it differed from the accepted level
        // for DEBOUNCE_CYCLES consecutive cycles.
        assign accept = (raw[i] != state_q) && (dcnt == DLAST);

        // Debounce filter; press/release are registered alongside the level so
        // they coincide with the first cycle of the new key_state.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                dcnt      <= '0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (raw[i] == state_q) begin
                    dcnt <= '0;
                end else if (accept) begin
                    state_q   <= raw[i];
                    press_q   <= raw[i];
                    release_q <= ~raw[i];
                    dcnt      <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        assign key_state[i]   = state_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;

        if (LONG_CYCLES > 0) begin : g_long
            logic [HW-1:0] hcnt;
            logic          rep_q;
            logic          long_q;

            // Hold timer. Cleared while released and on the release edge, so a
            // release never coincides with key_long. After the first long pulse
            // it either saturates or restarts as the repeat-period timer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hcnt   <= '0;
                    rep_q  <= 1'b0;
                    long_q <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (!state_q || accept) begin
                        hcnt  <= '0;
                        rep_q <= 1'b0;
                    end else if (!rep_q && hcnt == LLAST) begin
                        long_q <= 1'b1;
                        if (REPEAT_CYCLES > 0) begin
                            hcnt  <= '0;
                            rep_q <= 1'b1;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end else if (rep_q && hcnt == RLAST) begin
                        long_q <= 1'b1;
                        hcnt   <= '0;
                    end else if (hcnt != HSAT) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
            end

            assign key_long[i] = long_q;
        end else begin : g_nolong
            assign key_long[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
//
// Purpose:
//   Self-checking bench for key_debounce_multi. A default instance (no repeat)
//   is driven from a table of per-cycle vectors with hand-computed outputs;
//   hand-written sequences cover auto-repeat (second instance, REPEAT=5) and
//   reset in the middle of a held key.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

    typedef struct {
        logic       rst;
        logic [2:0] keys;
        logic [2:0] st;
        logic [2:0] pr;
        logic [2:0] rl;
        logic [2:0] lg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_in;
    logic [2:0] key_state, key_press, key_release, key_long;
    logic       rst_r;
    logic [2:0] key_in_r;
    logic [2:0] key_state_r, key_press_r, key_release_r, key_long_r;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    key_debounce_multi #(
        .N_KEYS(3), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(0)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(key_state), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );

    key_debounce_multi #(
        .N_KEYS(3), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(5)
    ) dut_rep (
        .clk(clk), .rst(rst_r), .key_in(key_in_r),
        .key_state(key_state_r), .key_press(key_press_r),
        .key_release(key_release_r), .key_long(key_long_r)
    );

    // Drive both instances for one cycle, then settle just after the edge.
    task automatic applyStimulus(input logic r, input logic [2:0] k,
                                 input logic rr, input logic [2:0] kr);
        rst      = r;
        key_in   = k;
        rst_r    = rr;
        key_in_r = kr;
        @(posedge clk);
        #1;
    endtask

    // Outputs compared as {state, press, release, long}.
    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got st/pr/rl/lg=%b expected %b", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic [2:0] k, input logic [2:0] s,
                          input logic [2:0] p, input logic [2:0] rl, input logic [2:0] l);
        vecs.push_back('{r, k, s, p, rl, l});
    endtask

    initial begin
        rst = 1'b1; key_in = 3'b111; rst_r = 1'b1; key_in_r = 3'b111;

        // Reset, then idle pins: everything quiet.
        for (int i = 0; i < 2; i++)  addVec(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 20; i++) addVec(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
        // Key 0 held: press at edge 5, single long at 15, release 5 edges after pin high.
        for (int i = 0; i <= 20; i++)
            addVec(1'b0, 3'b110, (i >= 5) ? 3'b001 : 3'b000, (i == 5) ? 3'b001 : 3'b000,
                   3'b000, (i == 15) ? 3'b001 : 3'b000);
        for (int i = 0; i < 10; i++)
            addVec(1'b0, 3'b111, (i < 5) ? 3'b001 : 3'b000, 3'b000,
                   (i == 5) ? 3'b001 : 3'b000, 3'b000);
        // Key 1 bounces low 3 / high 2: never accepted.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 3; i++) addVec(1'b0, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000);
            for (int i = 0; i < 2; i++) addVec(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
        end
        for (int i = 0; i < 8; i++) addVec(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
        // All keys together.
        for (int i = 0; i < 18; i++)
            addVec(1'b0, 3'b000, (i >= 5) ? 3'b111 : 3'b000, (i == 5) ? 3'b111 : 3'b000,
                   3'b000, (i == 15) ? 3'b111 : 3'b000);
        for (int i = 0; i < 10; i++)
            addVec(1'b0, 3'b111, (i < 5) ? 3'b111 : 3'b000, 3'b000,
                   (i == 5) ? 3'b111 : 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].keys, vecs[i].rst, 3'b111);
            checkOutput($sformatf("vec%0d", i), {key_state, key_press, key_release, key_long},
                        {vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].lg});
        end

        // Auto-repeat: key 2 pin low edges 0..30, press at 5, longs every 5 after +10,
        // release accepted at edge 36.
        for (int k = 0; k <= 40; k++) begin
            logic lg;
            lg = (k == 15) || (k == 20) || (k == 25) || (k == 30) || (k == 35);
            applyStimulus(1'b0, 3'b111, 1'b0, (k <= 30) ? 3'b011 : 3'b111);
            checkOutput($sformatf("rep_hold%0d", k),
                        {key_state_r, key_press_r, key_release_r, key_long_r},
                        {(k >= 5 && k < 36) ? 3'b100 : 3'b000, (k == 5) ? 3'b100 : 3'b000,
                         (k == 36) ? 3'b100 : 3'b000, lg ? 3'b100 : 3'b000});
        end
        // Short press on the repeat instance: released before any long.
        for (int k = 0; k <= 20; k++) begin
            applyStimulus(1'b0, 3'b111, 1'b0, (k <= 6) ? 3'b011 : 3'b111);
            checkOutput($sformatf("rep_short%0d", k),
                        {key_state_r, key_press_r, key_release_r, key_long_r},
                        {(k >= 5 && k < 12) ? 3'b100 : 3'b000, (k == 5) ? 3'b100 : 3'b000,
                         (k == 12) ? 3'b100 : 3'b000, 3'b000});
        end

        // Reset in the middle of a hold (hcnt=6 after edge 11), two reset cycles,
        // then the still-held key is accepted afresh at edge 19 and goes long at 29.
        for (int k = 0; k <= 40; k++) begin
            logic r;
            logic [2:0] s, p, l;
            r = (k == 12) || (k == 13);
            if (k < 12) begin
                s = (k >= 5) ? 3'b001 : 3'b000;
                p = (k == 5) ? 3'b001 : 3'b000;
                l = 3'b000;
            end else begin
                s = (k >= 19) ? 3'b001 : 3'b000;
                p = (k == 19) ? 3'b001 : 3'b000;
                l = (k == 29) ? 3'b001 : 3'b000;
            end
            applyStimulus(r, 3'b110, 1'b0, 3'b111);
            checkOutput($sformatf("midrst%0d", k), {key_state, key_press, key_release, key_long},
                        {s, p, 3'b000, l});
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 3'b111, 1'b0, 3'b111);
            checkOutput($sformatf("midrst_rel%0d", k), {key_state, key_press, key_release, key_long},
                        {(k < 5) ? 3'b001 : 3'b000, 3'b000, (k == 5) ? 3'b001 : 3'b000, 3'b000});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
